apb_slave_mem: RTL and testbench

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_slave_mem.sv | 134 +++++++++++++
 tb/tb_apb_slave_mem.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave in front of a DEPTH-word memory with byte-lane
// writes, programmable wait states and an error response for out-of-range
// word addresses. The request is captured when the setup phase is seen, so
// bus changes during the access phase cannot disturb a transfer in flight.
module apb_slave_mem #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 2
) (
   input  logic                    Pclk,
   input  logic                    Prst,
   input  logic                    Pselx,
   input  logic                    Penable,
   input  logic                    Pwrite,
   input  logic [ADDR_WIDTH-1:0]   Paddr,
   input  logic [DATA_WIDTH-1:0]   Pwdata,
   input  logic [DATA_WIDTH/8-1:0] Pstrb,
   output logic                    Pready,
   output logic                    Pslverr,
   output logic [DATA_WIDTH-1:0]   Prdata
);

   localparam int NUM_LANES = DATA_WIDTH / 8;
   localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t                  state, state_next;
   logic [3:0]              count, count_next;
   logic                    start, complete, access_ok, in_range;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    write_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [NUM_LANES-1:0]    strb_q;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [DATA_WIDTH-1:0]   rdata_q, mem_word;
   logic [IDX_WIDTH-1:0]    idx;

   assign access_ok = Pselx && Penable;
   assign in_range  = (addr_q < ADDR_WIDTH'(DEPTH));
   assign idx       = addr_q[IDX_WIDTH-1:0];
   assign mem_word  = mem[idx];

   // Next-state, wait-counter and transfer-event decode
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_next = state;
      count_next = count;
      start      = 1'b0;
      complete   = 1'b0;
      case (state)
         IDLE: begin
            // Penable without a preceding setup phase is ignored here.
            if (Pselx && !Penable) start = 1'b1;
         end
         SETUP: state_next = ACCESS;
         ACCESS: begin
            if (!access_ok) begin
               state_next = IDLE;
            end else if (count != 4'd0) begin
               count_next = count - 4'd1;
            end else begin
               // Completion needs Penable=1, so the next setup cycle is always
               // picked up from IDLE; Pselx may stay high between transfers.
               complete   = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (start) begin
         state_next = SETUP;
         count_next = 4'(WAIT_STATES);
      end
   end

   // State and wait-counter registers
   always_ff @(posedge Pclk or posedge Prst) begin
      // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
      if (Prst) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   // Capture the request when the setup phase is accepted
   always_ff @(posedge Pclk or posedge Prst) begin
      if (Prst) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
      end else if (start) begin
         addr_q  <= Paddr;
         write_q <= Pwrite;
         wdata_q <= Pwdata;
         strb_q  <= Pstrb;
      end
   end

   // Memory array: byte-lane update on a completed in-range write
   always_ff @(posedge Pclk or posedge Prst) begin
      // NOTE: reset must clear every word, so the array is built from resettable flops rather than a RAM.
      if (Prst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (complete && write_q && in_range) begin
         for (int b = 0; b < NUM_LANES; b++) begin
            if (strb_q[b]) mem[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
         end
      end
   end

   // Held read data: refreshed only when a read completes
   always_ff @(posedge Pclk or posedge Prst) begin
      if (Prst) rdata_q <= '0;
      else if (complete && !write_q) rdata_q <= in_range ? mem_word : '0;
   end

   // Bus response: ready, error and read data during the completion cycle
   always_comb begin
      Pready  = complete;
      Pslverr = complete && !in_range;
      Prdata  = rdata_q;
      if (complete) begin
         if (!in_range)     Prdata = '0;
         else if (!write_q) Prdata = mem_word;
      end
   end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: a transfer-level model (memory array, age of the
// current transfer, last read value) predicts Pready/Pslverr/Prdata every
// cycle; directed transfers pin the model with literal values, then random
// transfers with aborts, resets and bus noise run against it. A second
// instance with no wait states covers back-to-back timing.
module tb_apb_slave_mem;

   localparam int WS    = 2;
   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0] paddr = '0, pwdata = '0;
   logic [3:0]  pstrb = '0;
   logic        pready, pslverr;
   logic [31:0] prdata;

   logic        z_sel = 1'b0, z_en = 1'b0, z_wr = 1'b0;
   logic [31:0] z_addr = '0, z_wdata = '0;
   logic [3:0]  z_strb = 4'hF;
   logic        z_rdy, z_err;
   logic [31:0] z_rd;

   int checks = 0;
   int errors = 0;

   logic        s_rdy, s_err, zs_rdy;
   logic [31:0] s_rd, zs_rd;

   // transfer-level model
   logic [31:0] m_mem [DEPTH];
   bit          m_active = 1'b0;
   int          m_age = 0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_last = '0;
   bit          m_wr = 1'b0;
   logic [3:0]  m_strb = '0;

   always #5 clk = ~clk;

   apb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
      .Pclk(clk), .Prst(rst), .Pselx(psel), .Penable(penable), .Pwrite(pwrite),
      .Paddr(paddr), .Pwdata(pwdata), .Pstrb(pstrb),
      .Pready(pready), .Pslverr(pslverr), .Prdata(prdata));

   apb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
      .Pclk(clk), .Prst(rst), .Pselx(z_sel), .Penable(z_en), .Pwrite(z_wr),
      .Paddr(z_addr), .Pwdata(z_wdata), .Pstrb(z_strb),
      .Pready(z_rdy), .Pslverr(z_err), .Prdata(z_rd));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // expected outputs for the current cycle, from the model and live inputs
   task automatic compare_cycle();
      logic        e_rdy, e_err;
      logic [31:0] e_rd;
      if (rst) begin
         e_rdy = 1'b0; e_err = 1'b0; e_rd = '0;
      end else begin
         e_rdy = m_active && (m_age >= WS + 1) && psel && penable;
         e_err = e_rdy && (m_addr >= DEPTH);
         if (!e_rdy)             e_rd = m_last;
         else if (m_addr >= DEPTH) e_rd = '0;
         else if (m_wr)          e_rd = m_last;
         else                    e_rd = m_mem[m_addr[5:0]];
      end
      check("cyc_pready", 32'(pready), 32'(e_rdy));
      check("cyc_pslverr", 32'(pslverr), 32'(e_err));
      check("cyc_prdata", prdata, e_rd);
   endtask

   // advance the model across one rising edge using pre-edge inputs
   task automatic model_update();
      bit was_idle;
      if (rst) begin
         m_active = 1'b0; m_age = 0; m_last = '0;
         for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
         return;
      end
      was_idle = !m_active;
      if (m_active) begin
         if (m_age >= 1 && !(psel && penable)) begin
            m_active = 1'b0;
         end else if (m_age >= WS + 1) begin
            if (m_addr < DEPTH) begin
               if (m_wr) begin
                  for (int b = 0; b < 4; b++)
                     if (m_strb[b]) m_mem[m_addr[5:0]][8*b +: 8] = m_wdata[8*b +: 8];
               end else begin
                  m_last = m_mem[m_addr[5:0]];
               end
            end else if (!m_wr) begin
               m_last = '0;
            end
            m_active = 1'b0;
         end else begin
            m_age++;
         end
      end
      if (was_idle && psel && !penable) begin
         m_addr = paddr; m_wr = pwrite; m_wdata = pwdata; m_strb = pstrb;
         m_age = 0; m_active = 1'b1;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      s_rdy = pready; s_err = pslverr; s_rd = prdata;
      zs_rdy = z_rdy; zs_rd = z_rd;
      compare_cycle();
      @(posedge clk);
      model_update();
      #1;
   endtask

   // abort_mode: 0 none, 1 drop Penable, 2 assert reset, 3 drop Pselx
   task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input int abort_mode, input int abort_at,
                       output logic [31:0] rdata, output bit done, output int lows, output bit err);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      tick();
      penable = 1'b1; done = 1'b0; lows = 0; rdata = '0; err = 1'b0;
      for (int n = 0; n < 20 && !done; n++) begin
         if (abort_mode != 0 && n == abort_at) begin
            case (abort_mode)
               1:       penable = 1'b0;
               3:       psel = 1'b0;
               default: rst = 1'b1;
            endcase
            tick();
            if (s_rdy) done = 1'b1;
            psel = 1'b0; penable = 1'b0;
            tick();
            rst = 1'b0;
            break;
         end
         tick();
         if (s_rdy) begin
            done = 1'b1; rdata = s_rd; err = s_err;
         end else begin
            lows++;
            paddr = $urandom; pwdata = $urandom; pwrite = 1'($urandom); pstrb = 4'($urandom);
         end
      end
      psel = 1'b0; penable = 1'b0;
      if (abort_mode == 0 && !done) check("xfer_timeout", 32'd0, 32'd1);
   endtask

   // zero-wait-state instance: returns whether Pready was low then high
   task automatic z_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         output logic [31:0] rdata, output bit two_cycle);
      bit first;
      z_sel = 1'b1; z_en = 1'b0; z_wr = wr; z_addr = addr; z_wdata = data;
      tick();
      z_en = 1'b1;
      tick();
      first = zs_rdy;
      tick();
      two_cycle = !first && zs_rdy;
      rdata = zs_rd;
      z_sel = 1'b0; z_en = 1'b0;
   endtask

   initial begin
      logic [31:0] rd, a, d, zr;
      logic [3:0]  st;
      bit          done, err, zok, wr;
      int          lows, r, mode, at;

      repeat (3) tick();
      check("reset_pready", 32'(s_rdy), 32'd0);
      check("reset_pslverr", 32'(s_err), 32'd0);
      check("reset_prdata", s_rd, 32'd0);
      rst = 1'b0;
      tick();

      xfer(1'b1, 3, 32'hDEADBEEF, 4'hF, 0, 0, rd, done, lows, err);
      check("w3_done", 32'(done), 32'd1);
      check("w3_access_waits", 32'(lows - 1), 32'd2);
      check("w3_pslverr", 32'(err), 32'd0);
      xfer(1'b0, 3, 32'h0, 4'h0, 0, 0, rd, done, lows, err);
      check("r3_data", rd, 32'hDEADBEEF);

      xfer(1'b1, 5, 32'h11223344, 4'hF, 0, 0, rd, done, lows, err);
      xfer(1'b1, 5, 32'hAABBCCDD, 4'h2, 0, 0, rd, done, lows, err);
      xfer(1'b0, 5, 32'h0, 4'h0, 0, 0, rd, done, lows, err);
      check("r5_lane_merge", rd, 32'h1122CC44);
      xfer(1'b1, 5, 32'hFFFFFFFF, 4'h0, 0, 0, rd, done, lows, err);
      check("w5_nostrb_pslverr", 32'(err), 32'd0);
      xfer(1'b0, 5, 32'h0, 4'h0, 0, 0, rd, done, lows, err);
      check("r5_nostrb_unchanged", rd, 32'h1122CC44);

      xfer(1'b0, 64, 32'h0, 4'h0, 0, 0, rd, done, lows, err);
      check("r64_pslverr", 32'(err), 32'd1);
      check("r64_prdata", rd, 32'd0);
      check("r64_access_waits", 32'(lows - 1), 32'd2);
      xfer(1'b1, 70, 32'h55555555, 4'hF, 0, 0, rd, done, lows, err);
      check("w70_pslverr", 32'(err), 32'd1);
      xfer(1'b0, 6, 32'h0, 4'h0, 0, 0, rd, done, lows, err);
      check("r6_alias_unchanged", rd, 32'd0);

      xfer(1'b1, 7, 32'h77777777, 4'hF, 1, 2, rd, done, lows, err);
      check("w7_abort_no_ready", 32'(done), 32'd0);
      xfer(1'b0, 7, 32'h0, 4'h0, 0, 0, rd, done, lows, err);
      check("r7_after_abort", rd, 32'd0);

      xfer(1'b0, 3, 32'h0, 4'h0, 0, 0, rd, done, lows, err);
      check("r3_before_reset", rd, 32'hDEADBEEF);
      xfer(1'b1, 8, 32'h88888888, 4'hF, 2, 2, rd, done, lows, err);
      check("midrst_pready", 32'(s_rdy), 32'd0);
      check("midrst_pslverr", 32'(s_err), 32'd0);
      check("midrst_prdata", s_rd, 32'd0);
      tick();
      xfer(1'b0, 8, 32'h0, 4'h0, 0, 0, rd, done, lows, err);
      check("r8_after_reset", rd, 32'd0);
      xfer(1'b0, 3, 32'h0, 4'h0, 0, 0, rd, done, lows, err);
      check("r3_cleared_by_reset", rd, 32'd0);

      psel = 1'b1; penable = 1'b1;
      tick();
      check("missing_setup_ignored", 32'(s_rdy), 32'd0);
      psel = 1'b0; penable = 1'b0;
      tick();

      z_xfer(1'b1, 1, 32'hA1A1A1A1, zr, zok);
      check("z_w1_two_cycles", 32'(zok), 32'd1);
      z_xfer(1'b1, 2, 32'hB2B2B2B2, zr, zok);
      check("z_w2_two_cycles", 32'(zok), 32'd1);
      z_xfer(1'b0, 1, 32'h0, zr, zok);
      check("z_r1_two_cycles", 32'(zok), 32'd1);
      check("z_r1_data", zr, 32'hA1A1A1A1);
      z_xfer(1'b0, 2, 32'h0, zr, zok);
      check("z_r2_data", zr, 32'hB2B2B2B2);

      for (int t = 0; t < 250; t++) begin
         wr = 1'($urandom);
         a  = $urandom_range(0, 71);
         if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 7);
         d  = $urandom;
         st = 4'($urandom);
         r  = $urandom_range(0, 99);
         mode = 0; at = 0;
         if (r < 8)       begin mode = 1; at = $urandom_range(0, 3); end
         else if (r < 12) begin mode = 3; at = $urandom_range(0, 3); end
         else if (r < 14) begin mode = 2; at = $urandom_range(0, 3); end
         if (r >= 94) begin
            psel = 1'b1; penable = 1'b1;
            tick();
            psel = 1'b0; penable = 1'b0;
         end
         xfer(wr, a, d, st, mode, at, rd, done, lows, err);
         repeat ($urandom_range(0, 2)) tick();
      end

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
